// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory, and holds the returned word for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic [31:0] branch_offset,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] next_pc;

  // Jump beats a taken branch; all adds wrap modulo 2^32.
  function automatic logic [31:0] calc_next_pc(
    input logic [31:0]        seq_pc,
    input logic [31:0]        held,
    input logic               br,
    input logic               z,
    input logic               jp,
    input logic signed [31:0] off
  );
    logic signed [31:0] scaled;
    scaled = off <<< 2;
    if (jp)
      return {seq_pc[31:28], held[25:0], 2'b00};
    else if (br && z)
      return seq_pc + $unsigned(scaled);
    else
      return seq_pc;
  endfunction

  assign pc_plus4 = pc_q + 32'd4;
  assign next_pc  = calc_next_pc(pc_plus4, instr_q, Branch, Zero, Jump,
                                 $signed(branch_offset));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Reset abandons any outstanding request and discards the held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expected fetch addresses and
// instructions from a next-PC reference model; a monitor pops and compares.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req, imem_ack, stall, Branch, Zero, Jump, instr_valid;
  logic [31:0] imem_addr, imem_rdata, branch_offset, instr, pc_out, pc_plus4;
  logic [5:0]  op;

  logic        w_reset, w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc_out, w_pc_plus4;
  logic [5:0]  w_op;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .Branch(Branch), .Zero(Zero), .Jump(Jump), .branch_offset(branch_offset),
    .instr(instr), .op(op), .instr_valid(instr_valid), .pc_out(pc_out),
    .pc_plus4(pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(1'b0),
    .Branch(1'b0), .Zero(1'b0), .Jump(1'b0), .branch_offset(32'h0),
    .instr(w_instr), .op(w_op), .instr_valid(w_valid), .pc_out(w_pc_out),
    .pc_plus4(w_pc_plus4)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] addr_q[$];
  logic [63:0] instr_q[$];
  logic [31:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC rule, written as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic br, input logic z, input logic jp,
                                             input logic [31:0] off);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jp) return {seq[31:28], ins[25:0], 2'b00};
    if (br && z) return seq + off * 32'd4;
    return seq;
  endfunction

  function automatic logic [31:0] off_to(input logic [31:0] target);
    return 32'($signed(target - exp_pc - 32'd4) >>> 2);
  endfunction

  // Monitor state
  logic        p_req = 1'b0, p_valid = 1'b0;
  logic [31:0] h_addr, h_instr, h_pc, h_p4;
  logic [5:0]  h_op;
  logic [63:0] m_e;
  logic [31:0] m_a;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        if (!p_valid) chk("valid_after_ack", 32'(instr_valid), 32'(p_req && imem_ack));
        chk("req_and_valid", 32'(imem_req && instr_valid), 32'd0);
        if (instr_valid && !p_valid) begin
          if (instr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL instr_unexpected: got %h expected no instruction", instr);
          end else begin
            m_e = instr_q.pop_front();
            chk("instr", instr, m_e[63:32]);
            chk("op", 32'(op), 32'(m_e[63:58]));
            chk("pc_out", pc_out, m_e[31:0]);
            chk("pc_plus4", pc_plus4, m_e[31:0] + 32'd4);
          end
        end
        if (p_valid) begin
          chk("hold_on_stall", 32'(instr_valid), 32'(stall));
          if (instr_valid) begin
            chk("instr_stable", instr, h_instr);
            chk("op_stable", 32'(op), 32'(h_op));
            chk("pc_stable", pc_out, h_pc);
            chk("pc4_stable", pc_plus4, h_p4);
          end else begin
            chk("req_after_consume", 32'(imem_req), 32'd1);
          end
        end
        if (imem_req && !p_req) begin
          if (addr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
          end else begin
            m_a = addr_q.pop_front();
            chk("fetch_addr", imem_addr, m_a);
          end
        end else if (imem_req) begin
          chk("addr_stable", imem_addr, h_addr);
        end
      end
      p_req   = imem_req;
      p_valid = instr_valid;
      h_addr  = imem_addr;
      h_instr = instr;
      h_op    = op;
      h_pc    = pc_out;
      h_p4    = pc_plus4;
    end
  end

  task automatic wait_req();
    int c = 0;
    while (!imem_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!imem_req) begin
      n_vec++; n_err++;
      $display("FAIL req_timeout: got imem_req=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic do_txn(input int lat, input logic [31:0] data, input int nst,
                        input logic br, input logic z, input logic jp, input logic [31:0] off);
    wait_req();
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      @(negedge clk);
    end
    imem_ack = 1'b1; imem_rdata = data;
    instr_q.push_back({data, exp_pc});
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
    for (int i = 0; i < nst; i++) begin
      stall = 1'b1;
      Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
      branch_offset = $urandom;
      @(negedge clk);
    end
    stall = 1'b0; Branch = br; Zero = z; Jump = jp; branch_offset = off;
    exp_pc = model_next(exp_pc, data, br, z, jp, off);
    addr_q.push_back(exp_pc);
    @(negedge clk);
    stall = 1'($urandom);
    Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
    branch_offset = $urandom;
  endtask

  task automatic rand_txn();
    logic [31:0] d = $urandom;
    logic [15:0] r = 16'($urandom);
    int lat = $urandom_range(0, 3);
    int nst = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
    if ($urandom_range(0, 3) == 0) d[31:26] = 6'h02;
    do_txn(lat, d, nst, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
           {{16{r[15]}}, r});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected end within 1ms");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; branch_offset = 32'h0;
    w_reset = 1'b1; w_ack = 1'b0; w_rdata = 32'h0;
    exp_pc = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_pc_plus4", pc_plus4, 32'h4);
    chk("reset_instr", instr, 32'h0);

    // Ack held high continuously: sequential fetch of 0x20 words.
    for (int k = 0; k <= 6; k++) addr_q.push_back(32'(4 * k));
    for (int k = 0; k <= 5; k++) instr_q.push_back({32'h0000_0020, 32'(4 * k)});
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    repeat (12) @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    exp_pc = 32'h18;
    chk("seq_addr_0x18", imem_addr, 32'h18);

    // Latency 3, then a 4-cycle stall on a load word.
    do_txn(3, 32'h8C01_0004, 4, 1'b0, 1'b0, 1'b0, 32'h0);
    do_txn(0, $urandom, 0, 1'b1, 1'b1, 1'b0, off_to(32'h10));
    chk("reach_0x10", imem_addr, 32'h10);
    do_txn(1, $urandom, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
    chk("branch_taken", imem_addr, 32'h0C);
    do_txn(0, $urandom, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_txn(2, $urandom, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    chk("branch_not_taken", imem_addr, 32'h14);
    do_txn(0, $urandom, 0, 1'b1, 1'b1, 1'b0, off_to(32'h1000_0040));
    chk("reach_0x10000040", imem_addr, 32'h1000_0040);
    do_txn(1, 32'h0800_0010, 2, 1'b1, 1'b1, 1'b1, $urandom);
    chk("jump_priority", imem_addr, 32'h1000_0040);

    for (int k = 0; k < 150; k++) rand_txn();

    // Reset coinciding with an ack while a request is outstanding.
    chk("pre_reset_req", 32'(imem_req), 32'd1);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    exp_pc = 32'h0;
    addr_q.push_back(32'h0);
    @(negedge clk);
    chk("rst_req_req", 32'(imem_req), 32'd0);
    chk("rst_req_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_addr", imem_addr, 32'h0);
    chk("rst_req_instr", instr, 32'h0);
    chk("rst_req_pc_plus4", pc_plus4, 32'h4);
    reset = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    chk("boot_then_req", 32'(imem_req), 32'd1);
    chk("boot_then_addr", imem_addr, 32'h0);
    chk("boot_then_valid", 32'(instr_valid), 32'd0);

    for (int k = 0; k < 30; k++) rand_txn();
    repeat (3) @(negedge clk);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    chk("instr_q_drained", 32'(instr_q.size()), 32'd0);

    // PC wrap on a second instance reset to the top word.
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_rst_req", 32'(w_req), 32'd0);
    w_reset = 1'b0; w_ack = 1'b1; w_rdata = 32'h0000_0020;
    @(negedge clk);
    chk("wrap_first_req", 32'(w_req), 32'd1);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", w_pc_plus4, 32'h0);
    @(negedge clk);
    chk("wrap_valid", 32'(w_valid), 32'd1);
    chk("wrap_instr", w_instr, 32'h0000_0020);
    chk("wrap_op", 32'(w_op), 32'd0);
    chk("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_second_req", 32'(w_req), 32'd1);
    chk("wrap_second_addr", w_addr, 32'h0);
    w_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
